// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - control bus between the multicycle controller and its datapath
interface multicycle_control_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic       negate_b;
    logic [3:0] alu_operation;
    logic       illegal_op;
    logic [3:0] state;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
               negate_b, alu_operation, illegal_op, state
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
               negate_b, alu_operation, illegal_op, state
    );
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle MIPS control FSM (add/and/or/sll/lw/sw/beq)
// Optional j instruction is enabled by defining MULTICYCLE_JUMP_EN.
`ifndef ALU_OPERATION_AND
`define ALU_OPERATION_AND 4'b0000
`endif
`ifndef ALU_OPERATION_OR
`define ALU_OPERATION_OR  4'b0001
`endif
`ifndef ALU_OPERATION_ADD
`define ALU_OPERATION_ADD 4'b0010
`endif
`ifndef ALU_OPERATION_SLL
`define ALU_OPERATION_SLL 4'b0011
`endif

module multicycle_control (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);
    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_MEM_ADDR  = 4'd2;
    localparam logic [3:0] S_MEM_READ  = 4'd3;
    localparam logic [3:0] S_MEM_WB    = 4'd4;
    localparam logic [3:0] S_MEM_WRITE = 4'd5;
    localparam logic [3:0] S_EXECUTE   = 4'd6;
    localparam logic [3:0] S_R_WB      = 4'd7;
    localparam logic [3:0] S_BRANCH    = 4'd8;
`ifdef MULTICYCLE_JUMP_EN
    localparam logic [3:0] S_JUMP      = 4'd9;
    localparam logic [5:0] OP_J        = 6'b000010;
`endif

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLL = 6'b000000;

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic       rtype_ok;
    logic       pc_write_c;
    logic       mem_read_c;
    logic       mem_write_c;
    logic       ir_write_c;
    logic       reg_write_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        rtype_ok = (bus.opcode == OP_RTYPE) &&
                   ((bus.funct == FN_ADD) || (bus.funct == FN_AND) ||
                    (bus.funct == FN_OR)  || (bus.funct == FN_SLL));
    end

    always_comb begin
        state_d           = S_FETCH;
        pc_write_c        = 1'b0;
        mem_read_c        = 1'b0;
        mem_write_c       = 1'b0;
        ir_write_c        = 1'b0;
        reg_write_c       = 1'b0;
        bus.pc_source     = 2'b00;
        bus.i_or_d        = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.alu_src_a     = 2'b00;
        bus.alu_src_b     = 2'b00;
        bus.negate_b      = 1'b0;
        bus.alu_operation = `ALU_OPERATION_ADD;
        bus.illegal_op    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read_c    = 1'b1;
                bus.alu_src_b = 2'b01;
                ir_write_c    = bus.mem_ready;
                pc_write_c    = bus.mem_ready;
                state_d       = bus.mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // Branch target is computed speculatively into ALUOut here.
                bus.alu_src_b = 2'b11;
                if (rtype_ok)
                    state_d = S_EXECUTE;
                else if ((bus.opcode == OP_LW) || (bus.opcode == OP_SW))
                    state_d = S_MEM_ADDR;
                else if (bus.opcode == OP_BEQ)
                    state_d = S_BRANCH;
`ifdef MULTICYCLE_JUMP_EN
                else if (bus.opcode == OP_J)
                    state_d = S_JUMP;
`endif
                else
                    bus.illegal_op = 1'b1;
            end
            S_MEM_ADDR: begin
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = 2'b10;
                state_d       = (bus.opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                bus.i_or_d = 1'b1;
                mem_read_c = 1'b1;
                state_d    = bus.mem_ready ? S_MEM_WB : S_MEM_READ;
            end
            S_MEM_WB: begin
                bus.mem_to_reg = 1'b1;
                reg_write_c    = 1'b1;
            end
            S_MEM_WRITE: begin
                bus.i_or_d  = 1'b1;
                mem_write_c = 1'b1;
                state_d     = bus.mem_ready ? S_FETCH : S_MEM_WRITE;
            end
            S_EXECUTE: begin
                // sll shifts rt (register B) by shamt, so operand A is reg B.
                bus.alu_src_a = (bus.funct == FN_SLL) ? 2'b10 : 2'b01;
                case (bus.funct)
                    FN_AND:  bus.alu_operation = `ALU_OPERATION_AND;
                    FN_OR:   bus.alu_operation = `ALU_OPERATION_OR;
                    FN_SLL:  bus.alu_operation = `ALU_OPERATION_SLL;
                    default: bus.alu_operation = `ALU_OPERATION_ADD;
                endcase
                state_d = S_R_WB;
            end
            S_R_WB: begin
                bus.reg_dst = 1'b1;
                reg_write_c = 1'b1;
            end
            S_BRANCH: begin
                bus.alu_src_a = 2'b01;
                bus.negate_b  = 1'b1;
                bus.pc_source = 2'b01;
                pc_write_c    = bus.zero;
            end
`ifdef MULTICYCLE_JUMP_EN
            S_JUMP: begin
                bus.pc_source = 2'b10;
                pc_write_c    = 1'b1;
            end
`endif
            default: state_d = S_FETCH;
        endcase
    end

    // Strobes are gated by reset so an aborted access drops without waiting for a clock edge.
    assign bus.pc_write  = pc_write_c  & ~reset;
    assign bus.mem_read  = mem_read_c  & ~reset;
    assign bus.mem_write = mem_write_c & ~reset;
    assign bus.ir_write  = ir_write_c  & ~reset;
    assign bus.reg_write = reg_write_c & ~reset;
    assign bus.state     = state_q;
endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed self-checking bench for multicycle_control
`ifndef ALU_OPERATION_AND
`define ALU_OPERATION_AND 4'b0000
`endif
`ifndef ALU_OPERATION_OR
`define ALU_OPERATION_OR  4'b0001
`endif
`ifndef ALU_OPERATION_ADD
`define ALU_OPERATION_ADD 4'b0010
`endif
`ifndef ALU_OPERATION_SLL
`define ALU_OPERATION_SLL 4'b0011
`endif

module tb_multicycle_control;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   fails  = 0;

    multicycle_control_if bus ();

    multicycle_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [23:0] obs;
    assign obs = {bus.state, bus.pc_write, bus.pc_source, bus.i_or_d, bus.mem_read,
                  bus.mem_write, bus.ir_write, bus.reg_dst, bus.mem_to_reg, bus.reg_write,
                  bus.alu_src_a, bus.alu_src_b, bus.negate_b, bus.alu_operation, bus.illegal_op};

    function automatic logic [23:0] ev(input logic [3:0] st, input logic pw, input logic [1:0] ps,
                                       input logic iod, input logic mr, input logic mw,
                                       input logic irw, input logic rd, input logic m2r,
                                       input logic rw, input logic [1:0] sa, input logic [1:0] sb,
                                       input logic nb, input logic [3:0] op, input logic ill);
        return {st, pw, ps, iod, mr, mw, irw, rd, m2r, rw, sa, sb, nb, op, ill};
    endfunction

    localparam logic [23:0] V_FETCH      = ev(4'd0, 1, 2'b00, 0, 1, 0, 1, 0, 0, 0, 2'b00, 2'b01, 0, `ALU_OPERATION_ADD, 0);
    localparam logic [23:0] V_FETCH_WAIT = ev(4'd0, 0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 0, `ALU_OPERATION_ADD, 0);
    localparam logic [23:0] V_FETCH_RST  = ev(4'd0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 0, `ALU_OPERATION_ADD, 0);
    localparam logic [23:0] V_DECODE     = ev(4'd1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 0, `ALU_OPERATION_ADD, 0);
    localparam logic [23:0] V_DECODE_ILL = ev(4'd1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 0, `ALU_OPERATION_ADD, 1);
    localparam logic [23:0] V_MADDR      = ev(4'd2, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 0, `ALU_OPERATION_ADD, 0);
    localparam logic [23:0] V_MREAD      = ev(4'd3, 0, 2'b00, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, `ALU_OPERATION_ADD, 0);
    localparam logic [23:0] V_MWB        = ev(4'd4, 0, 2'b00, 0, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00, 0, `ALU_OPERATION_ADD, 0);
    localparam logic [23:0] V_MWRITE     = ev(4'd5, 0, 2'b00, 1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, `ALU_OPERATION_ADD, 0);
    localparam logic [23:0] V_EXEC_ADD   = ev(4'd6, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0, `ALU_OPERATION_ADD, 0);
    localparam logic [23:0] V_EXEC_OR    = ev(4'd6, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0, `ALU_OPERATION_OR, 0);
    localparam logic [23:0] V_EXEC_SLL   = ev(4'd6, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0, `ALU_OPERATION_SLL, 0);
    localparam logic [23:0] V_RWB        = ev(4'd7, 0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 2'b00, 2'b00, 0, `ALU_OPERATION_ADD, 0);
    localparam logic [23:0] V_BR_TAKEN   = ev(4'd8, 1, 2'b01, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 1, `ALU_OPERATION_ADD, 0);
    localparam logic [23:0] V_BR_NOT     = ev(4'd8, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 1, `ALU_OPERATION_ADD, 0);
`ifdef MULTICYCLE_JUMP_EN
    localparam logic [23:0] V_JUMP       = ev(4'd9, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, `ALU_OPERATION_ADD, 0);
`endif

    task automatic test_reset();
        reset = 1'b1;
        bus.opcode = 6'd0; bus.funct = 6'd0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (obs !== V_FETCH_RST) begin
            fails++; $display("FAIL reset_hold: got %h expected %h", obs, V_FETCH_RST);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (obs !== V_FETCH) begin
            fails++; $display("FAIL reset_release: got %h expected %h", obs, V_FETCH);
        end
    endtask

    task automatic test_add();
        logic [23:0] exp [4] = '{V_FETCH, V_DECODE, V_EXEC_ADD, V_RWB};
        bus.opcode = 6'b000000; bus.funct = 6'b100000; bus.mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1; checks++;
            if (obs !== exp[i]) begin
                fails++; $display("FAIL add cyc%0d: got %h expected %h", i, obs, exp[i]);
            end
            @(negedge clk);
        end
        checks++;
        if (obs !== V_FETCH) begin fails++; $display("FAIL add_end: got %h expected %h", obs, V_FETCH); end
    endtask

    task automatic test_sll();
        logic [23:0] exp [4] = '{V_FETCH, V_DECODE, V_EXEC_SLL, V_RWB};
        bus.opcode = 6'b000000; bus.funct = 6'b000000; bus.mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1; checks++;
            if (obs !== exp[i]) begin
                fails++; $display("FAIL sll cyc%0d: got %h expected %h", i, obs, exp[i]);
            end
            @(negedge clk);
        end
        checks++;
        if (obs !== V_FETCH) begin fails++; $display("FAIL sll_end: got %h expected %h", obs, V_FETCH); end
    endtask

    task automatic test_or();
        logic [23:0] exp [4] = '{V_FETCH, V_DECODE, V_EXEC_OR, V_RWB};
        bus.opcode = 6'b000000; bus.funct = 6'b100101; bus.mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1; checks++;
            if (obs !== exp[i]) begin
                fails++; $display("FAIL or cyc%0d: got %h expected %h", i, obs, exp[i]);
            end
            @(negedge clk);
        end
        checks++;
        if (obs !== V_FETCH) begin fails++; $display("FAIL or_end: got %h expected %h", obs, V_FETCH); end
    endtask

    task automatic test_lw_wait();
        logic [23:0] exp [7] = '{V_FETCH, V_DECODE, V_MADDR, V_MREAD, V_MREAD, V_MREAD, V_MWB};
        logic [6:0]  rdy = 7'b1100111;
        bus.opcode = 6'b100011; bus.funct = 6'b000000;
        for (int i = 0; i < 7; i++) begin
            bus.mem_ready = rdy[i];
            #1; checks++;
            if (obs !== exp[i]) begin
                fails++; $display("FAIL lw_wait cyc%0d: got %h expected %h", i, obs, exp[i]);
            end
            @(negedge clk);
        end
        checks++;
        if (obs !== V_FETCH) begin fails++; $display("FAIL lw_end: got %h expected %h", obs, V_FETCH); end
    endtask

    task automatic test_sw_fetch_wait();
        logic [23:0] exp [5] = '{V_FETCH_WAIT, V_FETCH, V_DECODE, V_MADDR, V_MWRITE};
        logic [4:0]  rdy = 5'b11110;
        bus.opcode = 6'b101011; bus.funct = 6'b000000;
        for (int i = 0; i < 5; i++) begin
            bus.mem_ready = rdy[i];
            #1; checks++;
            if (obs !== exp[i]) begin
                fails++; $display("FAIL sw cyc%0d: got %h expected %h", i, obs, exp[i]);
            end
            @(negedge clk);
        end
        checks++;
        if (obs !== V_FETCH) begin fails++; $display("FAIL sw_end: got %h expected %h", obs, V_FETCH); end
    endtask

    task automatic test_beq(input logic z);
        logic [23:0] exp [3];
        exp = '{V_FETCH, V_DECODE, (z ? V_BR_TAKEN : V_BR_NOT)};
        bus.opcode = 6'b000100; bus.funct = 6'b000000; bus.mem_ready = 1'b1; bus.zero = z;
        for (int i = 0; i < 3; i++) begin
            #1; checks++;
            if (obs !== exp[i]) begin
                fails++; $display("FAIL beq_z%0d cyc%0d: got %h expected %h", z, i, obs, exp[i]);
            end
            @(negedge clk);
        end
        bus.zero = 1'b0;
        #1; checks++;
        if (obs !== V_FETCH) begin fails++; $display("FAIL beq_end: got %h expected %h", obs, V_FETCH); end
    endtask

    task automatic test_illegal();
        logic [23:0] exp [2] = '{V_FETCH, V_DECODE_ILL};
        bus.opcode = 6'b001000; bus.funct = 6'b000000; bus.mem_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1; checks++;
            if (obs !== exp[i]) begin
                fails++; $display("FAIL illegal cyc%0d: got %h expected %h", i, obs, exp[i]);
            end
            @(negedge clk);
        end
        #1; checks++;
        if (obs !== V_FETCH) begin fails++; $display("FAIL illegal_end: got %h expected %h", obs, V_FETCH); end
    endtask

    task automatic test_jump();
`ifdef MULTICYCLE_JUMP_EN
        logic [23:0] exp [3] = '{V_FETCH, V_DECODE, V_JUMP};
        localparam int N = 3;
`else
        logic [23:0] exp [2] = '{V_FETCH, V_DECODE_ILL};
        localparam int N = 2;
`endif
        bus.opcode = 6'b000010; bus.funct = 6'b000000; bus.mem_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            #1; checks++;
            if (obs !== exp[i]) begin
                fails++; $display("FAIL jump cyc%0d: got %h expected %h", i, obs, exp[i]);
            end
            @(negedge clk);
        end
        #1; checks++;
        if (obs !== V_FETCH) begin fails++; $display("FAIL jump_end: got %h expected %h", obs, V_FETCH); end
    endtask

    task automatic test_reset_mid_write();
        logic [23:0] exp [4] = '{V_FETCH, V_DECODE, V_MADDR, V_MWRITE};
        logic [3:0]  rdy = 4'b0111;
        bus.opcode = 6'b101011; bus.funct = 6'b000000;
        for (int i = 0; i < 4; i++) begin
            bus.mem_ready = rdy[i];
            #1; checks++;
            if (obs !== exp[i]) begin
                fails++; $display("FAIL rst_mid cyc%0d: got %h expected %h", i, obs, exp[i]);
            end
            @(negedge clk);
        end
        #1; checks++;
        if (obs !== V_MWRITE) begin fails++; $display("FAIL rst_mid_hold: got %h expected %h", obs, V_MWRITE); end
        #1 reset = 1'b1;
        #1; checks++;
        if (obs !== V_FETCH_RST) begin
            fails++; $display("FAIL rst_mid_async: got %h expected %h", obs, V_FETCH_RST);
        end
        @(negedge clk);
        reset = 1'b0; bus.mem_ready = 1'b1;
        #1; checks++;
        if (obs !== V_FETCH) begin fails++; $display("FAIL rst_mid_release: got %h expected %h", obs, V_FETCH); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sll();
        test_or();
        test_lw_wait();
        test_sw_fetch_wait();
        test_beq(1'b1);
        test_beq(1'b0);
        test_illegal();
        test_jump();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Moore/Mealy finite-state control unit for the multicycle MIPS datapath: sequences fetch, decode, execute, memory and write-back over several clock cycles, and is the driving end of the ALU interface. It generates the `alu_operation` code (using the `alu_operation_*` macros of single_defs.v) and operand selects, and consumes the ALU `zero` flag for branch resolution. The supported instruction set is the ALU's: add, and, or, sll, lw, sw, beq, plus optional j.

## Interface
- No parameters; opcode, funct and ALU codes come from single_defs.v.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; forces state to FETCH.
- opcode  in  6  instruction register [31:26].
- funct  in  6  instruction register [5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory handshake; access completes in a cycle where mem_ready=1.
- pc_write  out  1  PC load enable.
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- i_or_d  out  1  memory address: 0 PC, 1 ALUOut.
- mem_read, mem_write  out  1 each  memory strobes.
- ir_write  out  1  instruction register load.
- reg_dst  out  1  0 rt, 1 rd.
- mem_to_reg  out  1  0 ALUOut, 1 MDR.
- reg_write  out  1  register file write enable.
- alu_src_a  out  2  00 PC, 01 reg A, 10 reg B.
- alu_src_b  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
- negate_b  out  1  datapath two's-complements ALU operand2.
- alu_operation  out  4  ALU opcode.
- illegal_op  out  1  one-cycle pulse on unsupported instruction.
- state  out  4  current state, for debug.

## Operation
- States (encoding): FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXECUTE 6, R_WB 7, BRANCH 8, JUMP 9. Codes 10-15 are unreachable and go to FETCH.
- Unlisted outputs are 0. alu_operation defaults to add.
- FETCH: mem_read=1, src_a=00, src_b=01, add, pc_source=00. ir_write and pc_write equal mem_ready. Stay in FETCH while mem_ready=0, else go to DECODE.
- DECODE: src_a=00, src_b=11, add (branch target into ALUOut). Next state by opcode:
  - 000000 goes to EXECUTE if funct ∈ {100000 add, 100100 and, 100101 or, 000000 sll}.
  - 100011 or 101011 goes to MEM_ADDR.
  - 000100 goes to BRANCH.
  - 000010 goes to JUMP (JUMP_EN only).
  - Anything else: illegal_op=1, go to FETCH.
- MEM_ADDR: src_a=01, src_b=10, add. Go to MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: i_or_d=1, mem_read=1. Hold until mem_ready, then go to MEM_WB.
- MEM_WB: reg_dst=0, mem_to_reg=1, reg_write=1. Go to FETCH.
- MEM_WRITE: i_or_d=1, mem_write=1. Hold until mem_ready, then go to FETCH.
- EXECUTE: src_b=00; alu_operation from funct (add/and/or/sll). src_a=01, except sll uses src_a=10 (rt shifted by shamt). Go to R_WB.
- R_WB: reg_dst=1, reg_write=1. Go to FETCH.
- BRANCH: src_a=01, src_b=00, negate_b=1, add, pc_source=01, pc_write=zero (Mealy). Go to FETCH.
- JUMP: pc_source=10, pc_write=1. Go to FETCH.

## Timing
- State register updates on the rising edge of clk. Outputs decode combinationally from state, plus zero and mem_ready.
- While reset=1: state=FETCH and every strobe (pc_write, ir_write, mem_read, mem_write, reg_write) is forced to 0. First fetch starts on the first rising edge after reset deasserts.
- Cycles per instruction with mem_ready tied to 1: R-type 4, lw 5, sw 4, beq 3, j 3, illegal 2.
- Each mem_ready=0 cycle in FETCH, MEM_READ or MEM_WRITE adds one cycle. Strobes stay asserted and the address stays stable while waiting.
- Reset mid-instruction aborts immediately. Any partially issued memory access is dropped; the PC is untouched unless pc_write already fired.

## Configuration
- MULTICYCLE_JUMP_EN defined: opcode 000010 goes DECODE -> JUMP -> FETCH.
- MULTICYCLE_JUMP_EN undefined: JUMP state is absent and opcode 000010 raises illegal_op. pc_source=10 is never driven.

## Test plan
- add: opcode=0, funct=100000, mem_ready=1 -> states 0,1,6,7,0. In EXECUTE alu_operation=`alu_operation_add, src_a=01. reg_write=1, reg_dst=1 only in R_WB.
- sll: funct=000000 -> EXECUTE drives `alu_operation_sll` with src_a=10.
- lw with mem_ready low for 2 cycles in MEM_READ -> MEM_READ lasts 3 cycles with mem_read=1, i_or_d=1. MEM_WB gives reg_write=1, mem_to_reg=1. Total 7 cycles.
- beq with zero=1 -> BRANCH pc_write=1, pc_source=01, negate_b=1. Same with zero=0 -> pc_write=0. Both return to FETCH.
- opcode=001000 -> illegal_op pulses for 1 cycle in DECODE, then FETCH. j asserts illegal_op only without MULTICYCLE_JUMP_EN.
- reset asserted in MEM_WRITE -> state=0 and mem_write=0 within the same cycle, without waiting for a clock edge.
